conv3x3_stream_io: RTL and testbench

Byte-stream front/back end for the 3x3 convolution controller (`conv_3x3`). Accepts a frame of 9 weights and a 4x4 input map on a valid/ready input stream and presents them on the controller's parallel buses. It pulses `weight_load` and `start`, captures each of the four single-cycle convolution results at its fixed slot, and returns the results as a 4-byte valid/ready output stream. It sits between the host/DMA byte interface and `conv_3x3`, and shares `clk`/`rst` with it.

---
 rtl/conv3x3_stream_io.sv | 199 +++++++++++++++++++
 tb/tb_conv3x3_stream_io.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_io.sv
// Byte-stream wrapper for conv_3x3: loads 9 weights + 16 map bytes, pulses the controller, streams 4 results.
// Optional weight reuse (skip the weight phase on a frame) is enabled by defining CONV3X3_IO_WREUSE_EN.
module conv3x3_stream_io (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [7:0]   s_data,
    input  logic         reuse_w,
    output logic [71:0]  w_flat,
    output logic [127:0] in_flat,
    output logic         weight_load,
    output logic         start,
    input  logic [31:0]  conv_out,
    input  logic         conv_done,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [7:0]   m_data,
    output logic         m_last,
    output logic         err
);

    typedef enum logic [2:0] {
        LOAD_W = 3'd0,
        LOAD_A = 3'd1,
        KICK   = 3'd2,
        GO     = 3'd3,
        RUN    = 3'd4,
        SEND   = 3'd5
    } state_t;

    state_t         state_r;
    logic [3:0]     idx_r;
    logic [3:0]     c_r;
    logic [1:0]     ridx_r;
    logic [31:0]    res_r;
    logic           skip_kick_r;
    logic           frame_done_r;
    logic           s_ready_r;
    logic [71:0]    w_flat_r;
    logic [127:0]   in_flat_r;
    logic           weight_load_r;
    logic           start_r;
    logic           m_valid_r;
    logic [7:0]     m_data_r;
    logic           m_last_r;
    logic           err_r;
    logic           take_s;
    logic           reuse_hit_s;

    function automatic logic [7:0] res_byte(input logic [31:0] res, input logic [1:0] sel);
        case (sel)
            2'd0:    res_byte = res[7:0];
            2'd1:    res_byte = res[15:8];
            2'd2:    res_byte = res[23:16];
            default: res_byte = res[31:24];
        endcase
    endfunction

    assign take_s = s_valid && s_ready_r;

`ifdef CONV3X3_IO_WREUSE_EN
    assign reuse_hit_s = reuse_w && frame_done_r && (idx_r == 4'd0);
`else
    logic unused_reuse_s;
    assign reuse_hit_s    = 1'b0;
    assign unused_reuse_s = reuse_w ^ frame_done_r;
`endif

    // Frame sequencer: byte capture, controller pulses, positional result capture and result streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= LOAD_W;
            idx_r         <= 4'd0;
            c_r           <= 4'd0;
            ridx_r        <= 2'd0;
            res_r         <= 32'd0;
            skip_kick_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            s_ready_r     <= 1'b0;
            w_flat_r      <= 72'd0;
            in_flat_r     <= 128'd0;
            weight_load_r <= 1'b0;
            start_r       <= 1'b0;
            m_valid_r     <= 1'b0;
            m_data_r      <= 8'd0;
            m_last_r      <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            weight_load_r <= 1'b0;
            start_r       <= 1'b0;
            case (state_r)
                LOAD_W: begin
                    s_ready_r <= 1'b1;
                    if (take_s) begin
                        if (reuse_hit_s) begin
                            in_flat_r[7:0] <= s_data;
                            idx_r          <= 4'd1;
                            skip_kick_r    <= 1'b1;
                            state_r        <= LOAD_A;
                        end else begin
                            w_flat_r[{idx_r, 3'b000} +: 8] <= s_data;
                            skip_kick_r <= 1'b0;
                            if (idx_r == 4'd8) begin
                                idx_r   <= 4'd0;
                                state_r <= LOAD_A;
                            end else begin
                                idx_r <= idx_r + 4'd1;
                            end
                        end
                    end
                end
                LOAD_A: begin
                    if (take_s) begin
                        in_flat_r[{idx_r, 3'b000} +: 8] <= s_data;
                        if (idx_r == 4'd15) begin
                            idx_r     <= 4'd0;
                            s_ready_r <= 1'b0;
                            // A reused weight set skips the load pulse and starts straight away.
                            if (skip_kick_r) begin
                                start_r <= 1'b1;
                                c_r     <= 4'd0;
                                state_r <= GO;
                            end else begin
                                weight_load_r <= 1'b1;
                                state_r       <= KICK;
                            end
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                KICK: begin
                    start_r <= 1'b1;
                    c_r     <= 4'd0;
                    state_r <= GO;
                end
                GO: begin
                    c_r     <= c_r + 4'd1;
                    state_r <= RUN;
                end
                RUN: begin
                    c_r <= c_r + 4'd1;
                    // Controller results are single-cycle, so each one is taken at a fixed offset from start.
                    case (c_r)
                        4'd4:  res_r[7:0]   <= conv_out[7:0];
                        4'd7:  res_r[15:8]  <= conv_out[15:8];
                        4'd10: res_r[23:16] <= conv_out[23:16];
                        4'd13: begin
                            res_r[31:24] <= conv_out[31:24];
                            if (!conv_done) begin
                                err_r <= 1'b1;
                            end
                            m_valid_r <= 1'b1;
                            m_data_r  <= res_r[7:0];
                            m_last_r  <= 1'b0;
                            ridx_r    <= 2'd0;
                            state_r   <= SEND;
                        end
                        default: begin
                        end
                    endcase
                end
                SEND: begin
                    if (m_ready) begin
                        if (ridx_r == 2'd3) begin
                            m_valid_r    <= 1'b0;
                            m_last_r     <= 1'b0;
                            ridx_r       <= 2'd0;
                            s_ready_r    <= 1'b1;
                            frame_done_r <= 1'b1;
                            state_r      <= LOAD_W;
                        end else begin
                            ridx_r   <= ridx_r + 2'd1;
                            m_data_r <= res_byte(res_r, ridx_r + 2'd1);
                            m_last_r <= (ridx_r == 2'd2);
                        end
                    end
                end
                default: begin
                    s_ready_r <= 1'b0;
                    idx_r     <= 4'd0;
                    state_r   <= LOAD_W;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_r;
    assign w_flat      = w_flat_r;
    assign in_flat     = in_flat_r;
    assign weight_load = weight_load_r;
    assign start       = start_r;
    assign m_valid     = m_valid_r;
    assign m_data      = m_data_r;
    assign m_last      = m_last_r;
    assign err         = err_r;

endmodule

// File: tb/tb_conv3x3_stream_io.sv
// Directed bench for conv3x3_stream_io with a positional stub of the conv_3x3 controller.
module tb_conv3x3_stream_io;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         reuse_w;
    logic [71:0]  w_flat;
    logic [127:0] in_flat;
    logic         weight_load;
    logic         start;
    logic [31:0]  conv_out;
    logic         conv_done;
    logic         m_valid;
    logic         m_ready;
    logic [7:0]   m_data;
    logic         m_last;
    logic         err;

    conv3x3_stream_io dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .reuse_w(reuse_w), .w_flat(w_flat), .in_flat(in_flat), .weight_load(weight_load),
        .start(start), .conv_out(conv_out), .conv_done(conv_done), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mv_cyc = 0;
    int wl_cnt = 0;
    int st_cnt = 0;
    int wl_cyc = 0;
    int st_cyc = 0;
    int k = -1;
    logic       done_en = 1'b1;
    logic [31:0] stub_res = 32'd0;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor
    always @(negedge clk) begin
        if (weight_load) begin
            wl_cnt <= wl_cnt + 1;
            wl_cyc <= cyc;
        end
        if (start) begin
            st_cnt <= st_cnt + 1;
            st_cyc <= cyc;
        end
    end

    // controller stub: results at S+4/7/10/13 after the start cycle S, conv_done at S+13
    always @(negedge clk) begin
        int kn;
        if (start) kn = 0;
        else if (k >= 0 && k < 100) kn = k + 1;
        else kn = -1;
        k <= kn;
        conv_out  <= 32'd0;
        conv_done <= 1'b0;
        case (kn)
            4:  conv_out <= {24'd0, stub_res[7:0]};
            7:  conv_out <= {16'd0, stub_res[15:8], 8'd0};
            10: conv_out <= {8'd0, stub_res[23:16], 16'd0};
            13: begin
                conv_out  <= {stub_res[31:24], 24'd0};
                conv_done <= done_en;
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("s_ready timeout", 128'(s_ready), 128'd1);
        acc_cyc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        reuse_w = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] base, input int nbytes, input bit gap);
        for (int i = 0; i < nbytes; i++) send_byte(base + 8'(i), gap);
    endtask

    task automatic recv_frame(input logic [31:0] exp, input bit stall);
        int n;
        logic [7:0] eb;
        for (int i = 0; i < 4; i++) begin
            eb = exp[8*i +: 8];
            n = 0;
            while (m_valid !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (n >= 60) check("m_valid timeout", 128'(m_valid), 128'd1);
            if (i == 0) begin
                mv_cyc = cyc;
                check("s_ready in SEND", 128'(s_ready), 128'd0);
            end
            if (stall) begin
                for (int j = 0; j < 5; j++) begin
                    check("stall m_data", 128'(m_data), 128'(eb));
                    check("stall m_valid", 128'(m_valid), 128'd1);
                    @(negedge clk);
                end
            end
            check("m_data", 128'(m_data), 128'(eb));
            check("m_last", 128'(m_last), (i == 3) ? 128'd1 : 128'd0);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
        check("m_valid after frame", 128'(m_valid), 128'd0);
        check("s_ready after frame", 128'(s_ready), 128'd1);
    endtask

    typedef struct {
        logic [7:0]  base;
        bit          gap;
        bit          stall;
        bit          done_en;
        logic [31:0] res;
        logic [7:0]  w0;
        logic [7:0]  w8;
        logic [7:0]  a0;
        logic [7:0]  a15;
        bit          err;
    } vec_t;

    vec_t v[5];

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl0, st0;
        logic [71:0] w_saved;

        v[0] = '{8'h01, 1'b0, 1'b0, 1'b1, 32'h22211211, 8'h01, 8'h09, 8'h0A, 8'h19, 1'b0};
        v[1] = '{8'h30, 1'b0, 1'b1, 1'b1, 32'hD4C3B2A1, 8'h30, 8'h38, 8'h39, 8'h48, 1'b0};
        v[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 32'h22211211, 8'h01, 8'h09, 8'h0A, 8'h19, 1'b0};
        v[3] = '{8'h50, 1'b0, 1'b0, 1'b0, 32'h0F0E0D0C, 8'h50, 8'h58, 8'h59, 8'h68, 1'b1};
        v[4] = '{8'h70, 1'b0, 1'b1, 1'b1, 32'h89674523, 8'h70, 8'h78, 8'h79, 8'h88, 1'b1};

        rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; reuse_w = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst s_ready", 128'(s_ready), 128'd0);
        check("rst weight_load", 128'(weight_load), 128'd0);
        check("rst start", 128'(start), 128'd0);
        check("rst m_valid", 128'(m_valid), 128'd0);
        check("rst m_last", 128'(m_last), 128'd0);
        check("rst m_data", 128'(m_data), 128'd0);
        check("rst err", 128'(err), 128'd0);
        check("rst w_flat", 128'(w_flat), 128'd0);
        check("rst in_flat", in_flat, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        check("s_ready after rst", 128'(s_ready), 128'd1);

        for (int i = 0; i < 5; i++) begin
            wl0 = wl_cnt; st0 = st_cnt;
            stub_res = v[i].res;
            done_en  = v[i].done_en;
            send_frame(v[i].base, 25, v[i].gap);
            recv_frame(v[i].res, v[i].stall);
            check("w_flat[7:0]", 128'(w_flat[7:0]), 128'(v[i].w0));
            check("w_flat[71:64]", 128'(w_flat[71:64]), 128'(v[i].w8));
            check("in_flat[7:0]", 128'(in_flat[7:0]), 128'(v[i].a0));
            check("in_flat[127:120]", 128'(in_flat[127:120]), 128'(v[i].a15));
            check("weight_load count", 128'(wl_cnt - wl0), 128'd1);
            check("start count", 128'(st_cnt - st0), 128'd1);
            check("kick latency", 128'(wl_cyc - acc_cyc), 128'd1);
            check("start latency", 128'(st_cyc - acc_cyc), 128'd2);
            check("m_valid latency", 128'(mv_cyc - st_cyc), 128'd14);
            check("err", 128'(err), 128'(v[i].err));
        end

        // reset after 12 bytes of a frame
        done_en = 1'b1;
        send_frame(8'h01, 12, 1'b0);
        rst = 1'b1;
        #1;
        check("mid rst s_ready", 128'(s_ready), 128'd0);
        check("mid rst w_flat", 128'(w_flat), 128'd0);
        check("mid rst err", 128'(err), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wl0 = wl_cnt; st0 = st_cnt;
        stub_res = 32'h5A4B3C2D;
        send_frame(8'hA0, 25, 1'b0);
        recv_frame(32'h5A4B3C2D, 1'b0);
        check("post rst w_flat[7:0]", 128'(w_flat[7:0]), 128'h0A0);
        check("post rst in_flat[7:0]", 128'(in_flat[7:0]), 128'h0A9);
        check("post rst weight_load count", 128'(wl_cnt - wl0), 128'd1);
        check("post rst start count", 128'(st_cnt - st0), 128'd1);
        check("post rst err", 128'(err), 128'd0);

        // weight reuse frame: 16 bytes only
        wl0 = wl_cnt; st0 = st_cnt;
        w_saved = w_flat;
        stub_res = 32'h77665544;
        reuse_w = 1'b1;
        send_frame(8'hC0, 16, 1'b0);
`ifdef CONV3X3_IO_WREUSE_EN
        recv_frame(32'h77665544, 1'b0);
        check("reuse weight_load count", 128'(wl_cnt - wl0), 128'd0);
        check("reuse start count", 128'(st_cnt - st0), 128'd1);
        check("reuse start latency", 128'(st_cyc - acc_cyc), 128'd1);
        check("reuse w_flat", 128'(w_flat), 128'(w_saved));
        check("reuse in_flat[7:0]", 128'(in_flat[7:0]), 128'h0C0);
        check("reuse in_flat[127:120]", 128'(in_flat[127:120]), 128'h0CF);
`else
        repeat (30) @(negedge clk);
        check("noreuse start count", 128'(st_cnt - st0), 128'd0);
        check("noreuse weight_load count", 128'(wl_cnt - wl0), 128'd0);
        check("noreuse s_ready", 128'(s_ready), 128'd1);
        check("noreuse m_valid", 128'(m_valid), 128'd0);
        check("noreuse w_flat[7:0]", 128'(w_flat[7:0]), 128'h0C0);
        check("noreuse in_flat[7:0]", 128'(in_flat[7:0]), 128'h0C9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
